// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage plus IF/ID pipeline register.
// It keeps one instruction-memory request in flight at a time and buffers
// returned words in a small prefetch FIFO. A word bypasses the FIFO when the
// FIFO is empty and Decode can accept it. Redirects from Decode or Execute
// clear the FIFO and drop wrong-path responses that are still in flight.
// Optional feature: define FETCH_PERF_EN to add the perf_fetched,
// perf_discarded and perf_bubbles counters and their output ports.
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2,
  parameter logic [31:0] NOP_INSTR  = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        StallF,
  input  logic        StallD,
  input  logic        FlushD,
  input  logic        redirect_D,
  input  logic [31:0] target_D,
  input  logic        redirect_E,
  input  logic [31:0] target_E,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr_D,
  output logic [31:0] pc_D,
  output logic        valid_D
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_discarded,
  output logic [31:0] perf_bubbles
`endif
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW:0] DEPTH_V = (CW + 1)'(FIFO_DEPTH);

  logic [31:0]   pc_f;
  logic [31:0]   req_pc;
  logic          outstanding;
  logic          discard;
  logic [31:0]   fifo_instr [FIFO_DEPTH];
  logic [31:0]   fifo_pc    [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;

  logic          redirect;
  logic [31:0]   redirect_pc;
  logic          out_eff;
  logic [CW:0]   occ;
  logic          issue;
  logic          rsp_live;
  logic          rsp_ok;
  logic          fifo_empty;
  logic          id_accept;
  logic          pop;
  logic          bypass;
  logic          push;

  // Execute's correction wins over Decode's prediction; the low address
  // bits are forced to zero so every request stays word aligned.
  assign redirect    = redirect_E | redirect_D;
  assign redirect_pc = (redirect_E ? target_E : target_D) & ~32'd3;

  // A response arriving this cycle frees the slot, so back-to-back requests
  // stream at one per cycle. The occupancy check still counts that response,
  // which guarantees it never lands on a full FIFO.
  assign out_eff  = outstanding & ~imem_rvalid;
  assign occ      = {1'b0, count} + {{CW{1'b0}}, outstanding};
  assign issue    = reset_n & ~redirect & ~StallF & ~out_eff & (occ < DEPTH_V);
  assign imem_req  = issue;
  assign imem_addr = pc_f;

  // Responses with nothing outstanding (e.g. left over from before a reset)
  // are ignored. A response arriving in a redirect cycle is wrong-path.
  assign rsp_live   = imem_rvalid & outstanding;
  assign rsp_ok     = rsp_live & ~discard & ~redirect;
  assign fifo_empty = (count == '0);
  assign id_accept  = ~FlushD & ~StallD;
  assign pop        = id_accept & ~fifo_empty;
  assign bypass     = rsp_ok & fifo_empty & id_accept;
  assign push       = rsp_ok & ~bypass;

  // Program counter, request tracking and wrong-path discard flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_f        <= RESET_PC;
      req_pc      <= RESET_PC;
      outstanding <= 1'b0;
      discard     <= 1'b0;
    end else begin
      if (redirect)   pc_f <= redirect_pc;
      else if (issue) pc_f <= pc_f + 32'd4;

      if (issue) begin
        outstanding <= 1'b1;
        req_pc      <= pc_f;
      end else if (imem_rvalid) begin
        outstanding <= 1'b0;
      end

      if (redirect)      discard <= outstanding & ~imem_rvalid;
      else if (rsp_live) discard <= 1'b0;
    end
  end

  // Prefetch FIFO pointers and occupancy; a redirect empties it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (redirect) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Prefetch FIFO storage; contents are only meaningful below count.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_instr[wr_ptr] <= imem_rdata;
      fifo_pc[wr_ptr]    <= req_pc;
    end
  end

  // IF/ID register: flush, then stall, then FIFO head, then bypass, else bubble.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      instr_D <= NOP_INSTR;
      pc_D    <= RESET_PC;
      valid_D <= 1'b0;
    end else if (FlushD) begin
      instr_D <= NOP_INSTR;
      valid_D <= 1'b0;
    end else if (!StallD) begin
      if (!fifo_empty) begin
        instr_D <= fifo_instr[rd_ptr];
        pc_D    <= fifo_pc[rd_ptr];
        valid_D <= 1'b1;
      end else if (bypass) begin
        instr_D <= imem_rdata;
        pc_D    <= req_pc;
        valid_D <= 1'b1;
      end else begin
        instr_D <= NOP_INSTR;
        valid_D <= 1'b0;
      end
    end
  end

`ifdef FETCH_PERF_EN
  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[32] ? 32'hFFFF_FFFF : s[31:0];
  endfunction

  logic [31:0] disc_inc;

  // Entries popped in the redirect cycle still reach Decode, so they are not
  // counted as cleared.
  assign disc_inc = 32'(rsp_live & (discard | redirect))
                  + (redirect ? (32'(count) - 32'(pop)) : 32'd0);

  // Saturating performance counters.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perf_fetched   <= '0;
      perf_discarded <= '0;
      perf_bubbles   <= '0;
    end else begin
      perf_fetched   <= sat_add(perf_fetched, 32'(rsp_ok));
      perf_discarded <= sat_add(perf_discarded, disc_inc);
      perf_bubbles   <= sat_add(perf_bubbles, 32'(~valid_D));
    end
  end
`endif

endmodule
